shift_reg_universal_sipo: RTL and testbench
===========================================

Name: shift_reg_universal_sipo

Overview:
- Parametrised universal shift register; successor to the fixed 8-bit left/right serial-in parallel-out register.
- Adds width, clock enable, rotate, parallel load and synchronous reset.
- Adds a word-assembly counter that captures a completed serial word into a holding register, with a one-cycle valid pulse.
- Sits between a serial pin/deserialiser front end and parallel word consumers.

Parameters:
WIDTH, 8, register and word width in bits; legal range is WIDTH >= 2.
RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q on reset.

Ports:
C  input  1  clock; all state changes on its rising edge.
R  input  1  reset, synchronous and active-high; has priority over every other input.
CE  input  1  clock enable; when low, all state holds and PO_VALID is 0.
MODE  input  3  operation: 000 hold, 001 shift left, 010 shift right, 011 rotate left, 100 rotate right, 101 parallel load, 110/111 hold.
SI  input  1  serial data in.
PI  input  WIDTH  parallel load data.
Q  output  WIDTH  live shift register contents.
SO_L  output  1  Q[WIDTH-1]; combinational.
SO_R  output  1  Q[0]; combinational.
PO  output  WIDTH  last completed word (holding register).
PO_VALID  output  1  one-cycle pulse; PO updated on this same edge.
BIT_CNT  output  $clog2(WIDTH)  serial bits accepted since the last word boundary.

Behaviour:
- Reset (R=1 at an edge): Q=RESET_VALUE, PO=0, PO_VALID=0, BIT_CNT=0. CE and MODE are ignored.
- Priority: R, then CE, then MODE.
- CE=0: Q, PO and BIT_CNT hold; PO_VALID=0.
- Shift left: Q <= {Q[WIDTH-2:0], SI}.
- Shift right: Q <= {SI, Q[WIDTH-1:1]}.
- Rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}. SI is ignored.
- Rotate right: Q <= {Q[0], Q[WIDTH-1:1]}. SI is ignored.
- Parallel load: Q <= PI.
- Hold (000, 110, 111): Q unchanged.
- All Q updates take effect at the edge (latency 1); there is no combinational path from SI/PI to Q.
- Counter rules:
  - BIT_CNT increments only on shift left/right with CE=1. Direction changes mid-word still count; bits are not reordered.
  - Rotate and hold leave BIT_CNT unchanged.
  - Parallel load clears BIT_CNT to 0, does not touch PO, and does not pulse PO_VALID.
- Word completion: a shift with BIT_CNT==WIDTH-1 does all of the following on the same edge:
  - BIT_CNT wraps to 0.
  - PO <= post-shift Q value, i.e. the new Q including this SI bit.
  - PO_VALID=1 for exactly that one cycle.
- PO_VALID is registered and otherwise 0.
- Back-to-back words need no idle cycle: a continuous shift stream yields a pulse every WIDTH enabled shifts.
- Reset mid-word discards the partial word; PO is cleared to 0.
- PO holds its value until the next word completion or reset.

Test Plan:
1. Reset with WIDTH=8: R=1 for 1 cycle with CE=1, MODE=001, SI=1 -> Q=0x00, PO=0x00, PO_VALID=0, BIT_CNT=0.
2. Shift left: MODE=001, SI=1,0,1,1,0,0,1,0 on 8 edges -> after edge 8 Q=0xB2, PO=0xB2, PO_VALID=1 for exactly one cycle, BIT_CNT=0. BIT_CNT=1..7 after edges 1..7, no earlier pulse.
3. Shift right: same SI sequence with MODE=010 -> Q=PO=0x4D, PO_VALID pulses at edge 8. SO_R tracks Q[0] each cycle.
4. Load and rotate: MODE=101, PI=0x81 -> Q=0x81, BIT_CNT=0. Rotate left once -> 0x03. Rotate right twice -> 0x81, then 0xC0. BIT_CNT stays 0; no PO_VALID; PO unchanged.
5. Enable gating and mid-word reset:
   - Shift in 5 bits, then hold CE=0 for 3 cycles with MODE=001 -> Q and BIT_CNT=5 frozen, PO_VALID=0.
   - Assert R -> Q=0, BIT_CNT=0, PO=0.
   - Next 8 shifts -> exactly one PO_VALID, at shift 8.
6. Streaming and load at boundary:
   - 16 consecutive left shifts -> PO_VALID at edges 8 and 16 only; PO holds word 1 between the two pulses.
   - Then shift 7 bits and apply parallel load -> BIT_CNT=0, no pulse, PO unchanged.

Source files
------------

// File: rtl/shift_reg_universal_sipo.sv
// Parametrised universal shift register with serial word assembly.
// A completed serial word is copied into PO with a one-cycle PO_VALID pulse.
module shift_reg_universal_sipo #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                     C,
  input  logic                     R,
  input  logic                     CE,
  input  logic [2:0]               MODE,
  input  logic                     SI,
  input  logic [WIDTH-1:0]         PI,
  output logic [WIDTH-1:0]         Q,
  output logic                     SO_L,
  output logic                     SO_R,
  output logic [WIDTH-1:0]         PO,
  output logic                     PO_VALID,
  output logic [$clog2(WIDTH)-1:0] BIT_CNT
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_ROL   = 3'b011,
    MODE_ROR   = 3'b100,
    MODE_LOAD  = 3'b101,
    MODE_HOLD6 = 3'b110,
    MODE_HOLD7 = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_next;
  logic [CW-1:0]    cnt_next;
  logic             word_done;

  always_comb begin
    q_next    = Q;
    cnt_next  = BIT_CNT;
    word_done = 1'b0;
    unique case (mode_e'(MODE))
      MODE_SHL: begin
        q_next    = {Q[WIDTH-2:0], SI};
        word_done = (BIT_CNT == LAST_BIT);
        cnt_next  = word_done ? '0 : BIT_CNT + 1'b1;
      end
      MODE_SHR: begin
        q_next    = {SI, Q[WIDTH-1:1]};
        word_done = (BIT_CNT == LAST_BIT);
        cnt_next  = word_done ? '0 : BIT_CNT + 1'b1;
      end
      MODE_ROL:  q_next = {Q[WIDTH-2:0], Q[WIDTH-1]};
      MODE_ROR:  q_next = {Q[0], Q[WIDTH-1:1]};
      MODE_LOAD: begin
        q_next   = PI;
        cnt_next = '0;
      end
      MODE_HOLD, MODE_HOLD6, MODE_HOLD7: ;
      default: ;
    endcase
  end

  // PO captures the post-shift word so the last serial bit lands in it
  always_ff @(posedge C) begin
    if (R) begin
      Q        <= RESET_VALUE;
      PO       <= '0;
      PO_VALID <= 1'b0;
      BIT_CNT  <= '0;
    end else if (CE) begin
      Q        <= q_next;
      BIT_CNT  <= cnt_next;
      PO_VALID <= word_done;
      if (word_done) PO <= q_next;
    end else begin
      PO_VALID <= 1'b0;
    end
  end

  assign SO_L = Q[WIDTH-1];
  assign SO_R = Q[0];

endmodule

// File: tb/tb_shift_reg_universal_sipo.sv
// Bench for shift_reg_universal_sipo: integer-arithmetic model checked every
// cycle, plus hand-computed expectations from the directed scenarios.
module tb_shift_reg_universal_sipo;
  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic             C = 1'b0;
  logic             R, CE, SI;
  logic [2:0]       MODE;
  logic [WIDTH-1:0] PI;
  logic [WIDTH-1:0] Q, PO;
  logic             SO_L, SO_R, PO_VALID;
  logic [$clog2(WIDTH)-1:0] BIT_CNT;

  shift_reg_universal_sipo #(.WIDTH(WIDTH)) dut (
    .C(C), .R(R), .CE(CE), .MODE(MODE), .SI(SI), .PI(PI),
    .Q(Q), .SO_L(SO_L), .SO_R(SO_R), .PO(PO), .PO_VALID(PO_VALID), .BIT_CNT(BIT_CNT)
  );

  always #5 C = ~C;

  int vec_count = 0;
  int err_count = 0;
  int m_q = 0, m_po = 0, m_cnt = 0;
  int m_valid = 0;
  bit model_live = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: Q as an integer in [0, 2^WIDTH); a word completes every WIDTH shifts
  task automatic applyStimulus(input bit r, input bit ce, input logic [2:0] mode,
                               input bit si, input logic [WIDTH-1:0] pi);
    bit shifted;
    R = r; CE = ce; MODE = mode; SI = si; PI = pi;
    @(posedge C);
    shifted = 1'b0;
    m_valid = 0;
    if (r) begin
      m_q = 0; m_po = 0; m_cnt = 0; model_live = 1'b1;
    end else if (ce) begin
      case (mode)
        3'd1: begin m_q = (m_q * 2 + int'(si)) % MOD; shifted = 1'b1; end
        3'd2: begin m_q = m_q / 2 + int'(si) * (MOD / 2); shifted = 1'b1; end
        3'd3: m_q = (m_q * 2) % MOD + m_q / (MOD / 2);
        3'd4: m_q = m_q / 2 + (m_q % 2) * (MOD / 2);
        3'd5: begin m_q = int'(pi); m_cnt = 0; end
        default: ;
      endcase
      if (shifted) begin
        m_cnt++;
        if (m_cnt == WIDTH) begin
          m_cnt = 0; m_po = m_q; m_valid = 1;
        end
      end
    end
    #1;
  endtask

  always @(negedge C) begin
    if (model_live) begin
      checkOutput("Q", 32'(Q), 32'(m_q));
      checkOutput("SO_L", 32'(SO_L), 32'((m_q / (MOD / 2)) % 2));
      checkOutput("SO_R", 32'(SO_R), 32'(m_q % 2));
      checkOutput("PO", 32'(PO), 32'(m_po));
      checkOutput("PO_VALID", 32'(PO_VALID), 32'(m_valid));
      checkOutput("BIT_CNT", 32'(BIT_CNT), 32'(m_cnt));
    end
  end

  initial begin
    logic [7:0] bits;
    logic [7:0] frozen_q;
    logic [7:0] word1, word2;
    int pulses;
    bits = 8'b1011_0010;

    // Reset with other controls active
    applyStimulus(1, 1, 3'b001, 1, 8'h5A);
    checkOutput("reset_q", 32'(Q), 32'h00);
    checkOutput("reset_po", 32'(PO), 32'h00);
    checkOutput("reset_valid", 32'(PO_VALID), 32'h0);
    checkOutput("reset_cnt", 32'(BIT_CNT), 32'h0);

    // Shift left one word, MSB first
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 3'b001, bits[7-i], 8'h00);
      checkOutput("shl_cnt", 32'(BIT_CNT), 32'((i + 1) % 8));
      checkOutput("shl_valid", 32'(PO_VALID), (i == 7) ? 32'h1 : 32'h0);
    end
    checkOutput("shl_q", 32'(Q), 32'hB2);
    checkOutput("shl_po", 32'(PO), 32'hB2);
    applyStimulus(0, 1, 3'b000, 0, 8'h00);
    checkOutput("shl_pulse_once", 32'(PO_VALID), 32'h0);

    // Same bits shifted right
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, 3'b010, bits[7-i], 8'h00);
    checkOutput("shr_q", 32'(Q), 32'h4D);
    checkOutput("shr_po", 32'(PO), 32'h4D);
    checkOutput("shr_valid", 32'(PO_VALID), 32'h1);

    // Load and rotate
    applyStimulus(0, 1, 3'b101, 0, 8'h81);
    checkOutput("load_q", 32'(Q), 32'h81);
    applyStimulus(0, 1, 3'b011, 0, 8'h00);
    checkOutput("rol_q", 32'(Q), 32'h03);
    applyStimulus(0, 1, 3'b100, 1, 8'h00);
    checkOutput("ror1_q", 32'(Q), 32'h81);
    applyStimulus(0, 1, 3'b100, 1, 8'h00);
    checkOutput("ror2_q", 32'(Q), 32'hC0);
    checkOutput("rot_cnt", 32'(BIT_CNT), 32'h0);
    checkOutput("rot_po", 32'(PO), 32'h4D);

    // Enable gating then mid-word reset
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 3'b001, 1, 8'h00);
    frozen_q = Q;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 3'b001, 0, 8'h00);
      checkOutput("ce_cnt", 32'(BIT_CNT), 32'h5);
      checkOutput("ce_q", 32'(Q), 32'(frozen_q));
      checkOutput("ce_valid", 32'(PO_VALID), 32'h0);
    end
    applyStimulus(1, 1, 3'b001, 1, 8'h00);
    checkOutput("midreset_q", 32'(Q), 32'h00);
    checkOutput("midreset_po", 32'(PO), 32'h00);
    checkOutput("midreset_cnt", 32'(BIT_CNT), 32'h0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 3'b001, 1, 8'h00);
      if (PO_VALID === 1'b1) pulses++;
    end
    checkOutput("after_reset_pulses", 32'(pulses), 32'h1);
    checkOutput("after_reset_po", 32'(PO), 32'hFF);

    // Streaming: two words back to back
    word1 = 8'h3C; word2 = 8'hA7;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, 1, 3'b001, (i < 8) ? word1[7-i] : word2[15-i], 8'h00);
      checkOutput("stream_valid", 32'(PO_VALID), (i == 7 || i == 15) ? 32'h1 : 32'h0);
      if (i >= 7 && i < 15) checkOutput("stream_po_hold", 32'(PO), 32'(word1));
    end
    checkOutput("stream_po2", 32'(PO), 32'(word2));
    for (int i = 0; i < 7; i++) applyStimulus(0, 1, 3'b001, 1, 8'h00);
    applyStimulus(0, 1, 3'b101, 0, 8'h11);
    checkOutput("load_bound_cnt", 32'(BIT_CNT), 32'h0);
    checkOutput("load_bound_valid", 32'(PO_VALID), 32'h0);
    checkOutput("load_bound_po", 32'(PO), 32'(word2));

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
                    3'($urandom_range(0, 7)), 1'($urandom), 8'($urandom));
    end

    @(negedge C);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
